// File: rtl/mem_lsu_ysyx23060136_pkg.sv
// MEM-stage LSU shared types: FSM states, AXI response codes,
// access-size one-hot indices and the alignment rule.
package mem_lsu_ysyx23060136_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_AR,
    LD_R,
    ST_AW,
    ST_B,
    DONE,
    ERR
  } lsu_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int SZ_BYTE   = 0;
  localparam int SZ_HALF   = 1;
  localparam int SZ_WORD   = 2;
  localparam int SZ_BYTE_U = 3;
  localparam int SZ_HALF_U = 4;
  localparam int SZ_N      = 5;

  function automatic logic lsu_misaligned(
    input logic [SZ_N-1:0] sz,
    input logic [1:0]      a
  );
    return ((sz[SZ_HALF] | sz[SZ_HALF_U]) & a[0])
         | (sz[SZ_WORD] & (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_align_ysyx23060136.sv
// Byte-lane steering: load extract/extend and store
// data shift plus write-strobe generation.
module mem_lsu_align_ysyx23060136
  import mem_lsu_ysyx23060136_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [SZ_N-1:0] size,
  input  logic [31:0]     rdata_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     ld_data_o,
  output logic [31:0]     st_data_o,
  output logic [3:0]      st_strb_o
);

  logic [4:0]  sh;
  logic [31:0] x;

  assign sh        = {addr_lo, 3'b000};
  assign x         = rdata_i >> sh;
  assign st_data_o = wdata_i << sh;

  always_comb begin
    ld_data_o = x;
    st_strb_o = 4'b0000;
    unique case (1'b1)
      size[SZ_BYTE]: begin
        ld_data_o = {{24{x[7]}}, x[7:0]};
        st_strb_o = 4'b0001 << addr_lo;
      end
      size[SZ_BYTE_U]: begin
        ld_data_o = {24'b0, x[7:0]};
        st_strb_o = 4'b0001 << addr_lo;
      end
      size[SZ_HALF]: begin
        ld_data_o = {{16{x[15]}}, x[15:0]};
        st_strb_o = 4'b0011 << addr_lo;
      end
      size[SZ_HALF_U]: begin
        ld_data_o = {16'b0, x[15:0]};
        st_strb_o = 4'b0011 << addr_lo;
      end
      size[SZ_WORD]: begin
        ld_data_o = x;
        st_strb_o = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu_ysyx23060136.sv
// MEM-stage load/store unit: one AXI4-Lite transaction
// per memory instruction, pipeline stalled while in flight.
module mem_lsu_ysyx23060136
  import mem_lsu_ysyx23060136_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEM_i_valid,
  input  logic [ADDR_W-1:0] MEM_i_addr,
  input  logic [DATA_W-1:0] MEM_i_wdata,
  input  logic              MEM_i_write_mem,
  input  logic              MEM_i_mem_to_reg,
  input  logic              MEM_i_byte,
  input  logic              MEM_i_half,
  input  logic              MEM_i_word,
  input  logic              MEM_i_byte_u,
  input  logic              MEM_i_half_u,
  output logic              MEM_o_stall,
  output logic              MEM_o_done,
  output logic [DATA_W-1:0] MEM_o_rdata,
  output logic              MEM_o_misalign,
  output logic              MEM_o_bus_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic [SZ_N-1:0]   size_q, size_d;
  logic              aw_acc_q, aw_acc_d;
  logic              w_acc_q, w_acc_d;
  logic              err_q, err_d;

  logic              req;
  logic [SZ_N-1:0]   size_in;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_data;
  logic [3:0]        st_strb;

  assign req = MEM_i_valid
             & (MEM_i_write_mem | MEM_i_mem_to_reg);
  assign size_in = {MEM_i_half_u, MEM_i_byte_u,
                    MEM_i_word, MEM_i_half, MEM_i_byte};

  mem_lsu_align_ysyx23060136 u_align (
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .rdata_i   (rdata),
    .wdata_i   (wdat_q),
    .ld_data_o (ld_data),
    .st_data_o (st_data),
    .st_strb_o (st_strb)
  );

  assign araddr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign awaddr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign wdata       = st_data;
  assign wstrb       = wvalid ? st_strb : 4'b0000;
  assign MEM_o_rdata = rdat_q;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdat_d         = wdat_q;
    rdat_d         = rdat_q;
    size_d         = size_q;
    aw_acc_d       = aw_acc_q;
    w_acc_d        = w_acc_q;
    err_d          = err_q;
    MEM_o_stall    = 1'b0;
    MEM_o_done     = 1'b0;
    MEM_o_misalign = 1'b0;
    MEM_o_bus_err  = 1'b0;
    arvalid        = 1'b0;
    rready         = 1'b0;
    awvalid        = 1'b0;
    wvalid         = 1'b0;
    bready         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          MEM_o_stall = 1'b1;
          addr_d      = MEM_i_addr;
          wdat_d      = MEM_i_wdata;
          size_d      = size_in;
          aw_acc_d    = 1'b0;
          w_acc_d     = 1'b0;
          err_d       = 1'b0;
          if (lsu_misaligned(size_in, MEM_i_addr[1:0]))
            state_d = ERR;
          else if (MEM_i_write_mem)
            state_d = ST_AW;
          else
            state_d = LD_AR;
        end
      end
      LD_AR: begin
        MEM_o_stall = 1'b1;
        arvalid     = 1'b1;
        if (arready) state_d = LD_R;
      end
      LD_R: begin
        MEM_o_stall = 1'b1;
        rready      = 1'b1;
        if (rvalid) begin
          rdat_d  = ld_data;
          err_d   = (rresp != AXI_RESP_OKAY);
          state_d = DONE;
        end
      end
      ST_AW: begin
        // AW and W retire independently; leave once both are in
        MEM_o_stall = 1'b1;
        awvalid     = !aw_acc_q;
        wvalid      = !w_acc_q;
        aw_acc_d    = aw_acc_q | awready;
        w_acc_d     = w_acc_q | wready;
        if (aw_acc_d && w_acc_d) state_d = ST_B;
      end
      ST_B: begin
        MEM_o_stall = 1'b1;
        bready      = 1'b1;
        if (bvalid) begin
          err_d   = (bresp != AXI_RESP_OKAY);
          state_d = DONE;
        end
      end
      DONE: begin
        MEM_o_done    = 1'b1;
        MEM_o_bus_err = err_q;
        state_d       = IDLE;
      end
      ERR: begin
        MEM_o_done     = 1'b1;
        MEM_o_misalign = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      size_q   <= '0;
      aw_acc_q <= 1'b0;
      w_acc_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      size_q   <= size_d;
      aw_acc_q <= aw_acc_d;
      w_acc_q  <= w_acc_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu_ysyx23060136.sv
// Bench for the MEM-stage LSU: directed cases plus random
// loads/stores against a byte-level reference and AXI slave.
module tb_mem_lsu_ysyx23060136;

  localparam int B  = 0;
  localparam int H  = 1;
  localparam int W  = 2;
  localparam int BU = 3;
  localparam int HU = 4;

  logic        clk;
  logic        rst_n;
  logic        MEM_i_valid;
  logic [31:0] MEM_i_addr;
  logic [31:0] MEM_i_wdata;
  logic        MEM_i_write_mem;
  logic        MEM_i_mem_to_reg;
  logic        MEM_i_byte;
  logic        MEM_i_half;
  logic        MEM_i_word;
  logic        MEM_i_byte_u;
  logic        MEM_i_half_u;
  logic        MEM_o_stall;
  logic        MEM_o_done;
  logic [31:0] MEM_o_rdata;
  logic        MEM_o_misalign;
  logic        MEM_o_bus_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_chk;
  int n_err;

  mem_lsu_ysyx23060136 dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .MEM_i_valid      (MEM_i_valid),
    .MEM_i_addr       (MEM_i_addr),
    .MEM_i_wdata      (MEM_i_wdata),
    .MEM_i_write_mem  (MEM_i_write_mem),
    .MEM_i_mem_to_reg (MEM_i_mem_to_reg),
    .MEM_i_byte       (MEM_i_byte),
    .MEM_i_half       (MEM_i_half),
    .MEM_i_word       (MEM_i_word),
    .MEM_i_byte_u     (MEM_i_byte_u),
    .MEM_i_half_u     (MEM_i_half_u),
    .MEM_o_stall      (MEM_o_stall),
    .MEM_o_done       (MEM_o_done),
    .MEM_o_rdata      (MEM_o_rdata),
    .MEM_o_misalign   (MEM_o_misalign),
    .MEM_o_bus_err    (MEM_o_bus_err),
    .araddr           (araddr),
    .arvalid          (arvalid),
    .arready          (arready),
    .rdata            (rdata),
    .rresp            (rresp),
    .rvalid           (rvalid),
    .rready           (rready),
    .awaddr           (awaddr),
    .awvalid          (awvalid),
    .awready          (awready),
    .wdata            (wdata),
    .wstrb            (wstrb),
    .wvalid           (wvalid),
    .wready           (wready),
    .bresp            (bresp),
    .bvalid           (bvalid),
    .bready           (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input int sz);
    if (sz == B || sz == BU) return 1;
    if (sz == H || sz == HU) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input int sz,
                                           input int off,
                                           input logic [31:0] rd);
    longint v;
    v = longint'(rd) >> (8 * off);
    case (sz)
      B: begin
        v = v % 256;
        if (v >= 128) v = v - 256;
      end
      BU: v = v % 256;
      H: begin
        v = v % 65536;
        if (v >= 32768) v = v - 65536;
      end
      HU: v = v % 65536;
      default: v = v % 64'h1_0000_0000;
    endcase
    return v[31:0];
  endfunction

  task automatic drive_req(input bit v, input bit st, input int sz,
                           input logic [31:0] a,
                           input logic [31:0] wd);
    MEM_i_valid      = v;
    MEM_i_write_mem  = v & st;
    MEM_i_mem_to_reg = v & !st;
    MEM_i_byte       = (sz == B);
    MEM_i_half       = (sz == H);
    MEM_i_word       = (sz == W);
    MEM_i_byte_u     = (sz == BU);
    MEM_i_half_u     = (sz == HU);
    MEM_i_addr       = a;
    MEM_i_wdata      = wd;
  endtask

  task automatic run_op(input bit st, input int sz,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] rd,
                        input logic [1:0] resp,
                        input int arw, input int rw,
                        input int aww, input int ww,
                        input int bw, input bit b2b);
    int nb;
    int off;
    bit mis;
    int s;
    int exp_lat;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    logic [31:0] exp_a;
    logic [3:0] exp_strb;
    int ar_hi;
    int r_hi;
    int aw_hi;
    int w_hi;
    int b_hi;
    int cyc;
    bit fin;
    nb = nbytes(sz);
    off = int'(a[1:0]);
    mis = (off % nb) != 0;
    s = ((1 << nb) - 1) << off;
    exp_strb = s[3:0];
    exp_rd = ref_load(sz, off, rd);
    exp_wd = wd << (8 * off);
    exp_a = a & 32'hFFFF_FFFC;
    if (mis) exp_lat = 1;
    else if (st) exp_lat = 3 + ((aww > ww) ? aww : ww) + bw;
    else exp_lat = 3 + arw + rw;
    ar_hi = 0; r_hi = 0; aw_hi = 0; w_hi = 0; b_hi = 0;
    cyc = 0;
    fin = 0;
    drive_req(1'b1, st, sz, a, wd);
    while (!fin && cyc < 64) begin
      #1;
      if (MEM_o_done) begin
        fin = 1;
        chk("latency", cyc, exp_lat);
        chk("stall_done", 32'(MEM_o_stall), 0);
        chk("misalign", 32'(MEM_o_misalign), 32'(mis));
        chk("bus_err", 32'(MEM_o_bus_err),
            32'(!mis && resp != 2'b00));
        if (!st && !mis) chk("load_data", MEM_o_rdata, exp_rd);
        chk("ar_cycles", ar_hi, (st || mis) ? 0 : arw + 1);
        chk("aw_cycles", aw_hi, (!st || mis) ? 0 : aww + 1);
        chk("w_cycles", w_hi, (!st || mis) ? 0 : ww + 1);
      end else begin
        chk("stall", 32'(MEM_o_stall), 1);
      end
      arready = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;
      if (arvalid) begin
        if (ar_hi >= arw) begin
          arready = 1'b1;
          chk("araddr", araddr, exp_a);
        end
        ar_hi++;
      end
      if (awvalid) begin
        if (aw_hi >= aww) begin
          awready = 1'b1;
          chk("awaddr", awaddr, exp_a);
        end
        aw_hi++;
      end
      if (wvalid) begin
        if (w_hi >= ww) begin
          wready = 1'b1;
          chk("wdata", wdata, exp_wd);
          chk("wstrb", 32'(wstrb), 32'(exp_strb));
        end
        w_hi++;
      end
      if (rready) begin
        rvalid = (r_hi >= rw);
        rdata  = rvalid ? rd : $urandom;
        rresp  = resp;
        r_hi++;
      end else begin
        rvalid = 1'($urandom_range(0, 1));
        rdata  = $urandom;
        rresp  = 2'($urandom);
      end
      if (bready) begin
        bvalid = (b_hi >= bw);
        bresp  = resp;
        b_hi++;
      end else begin
        bvalid = 1'($urandom_range(0, 1));
        bresp  = 2'($urandom);
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    if (b2b) drive_req(1'b1, 1'b0, W, 32'h8000_0010, 0);
    else drive_req(1'b0, 1'b0, W, 0, 0);
    @(negedge clk);
    #1;
    chk("done_pulse", 32'(MEM_o_done), 0);
    chk("idle_arvalid", 32'(arvalid), 0);
    chk("idle_stall", 32'(MEM_o_stall), 32'(b2b));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    arready = 0; awready = 0; wready = 0;
    rvalid = 0; bvalid = 0;
    rdata = 0; rresp = 0; bresp = 0;
    drive_req(1'b0, 1'b0, W, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_rdata", MEM_o_rdata, 0);
    chk("rst_valids",
        32'({arvalid, awvalid, wvalid, rready, bready, wstrb}), 0);
    chk("rst_pulses",
        32'({MEM_o_done, MEM_o_misalign, MEM_o_bus_err,
             MEM_o_stall}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    run_op(0, B, 32'h8000_0003, 0, 32'h8A00_0000, 2'b00,
           0, 0, 0, 0, 0, 0);
    run_op(0, HU, 32'h8000_0002, 0, 32'hBEEF_1234, 2'b00,
           4, 0, 0, 0, 0, 0);
    run_op(1, B, 32'h0000_1001, 32'h0000_00AB, 0, 2'b00,
           0, 0, 0, 2, 0, 0);
    run_op(0, W, 32'h0000_1002, 0, 32'h1234_5678, 2'b00,
           0, 0, 0, 0, 0, 0);
    run_op(1, W, 32'h0000_2000, 32'hDEAD_BEEF, 0, 2'b10,
           0, 0, 0, 0, 0, 1);
    run_op(0, W, 32'h8000_0010, 0, 32'hCAFE_F00D, 2'b00,
           0, 0, 0, 0, 0, 0);

    drive_req(1'b1, 1'b0, W, 32'h8000_0020, 0);
    rvalid = 0; bvalid = 0; arready = 1'b1;
    #1;
    chk("rst_stall_idle", 32'(MEM_o_stall), 1);
    @(negedge clk);
    #1;
    chk("rst_arvalid", 32'(arvalid), 1);
    @(negedge clk);
    arready = 1'b0;
    #1;
    chk("rst_rready", 32'(rready), 1);
    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, W, 0, 0);
    #1;
    chk("rst_async_arvalid", 32'(arvalid), 0);
    chk("rst_async_rready", 32'(rready), 0);
    chk("rst_async_stall", 32'(MEM_o_stall), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      #1;
      rvalid = 1'b1;
      rdata  = $urandom;
      chk("rst_no_done", 32'(MEM_o_done), 0);
      chk("rst_rready_off", 32'(rready), 0);
      @(negedge clk);
    end
    rvalid = 1'b0;
    #1;

    for (int i = 0; i < 300; i++) begin
      bit st;
      int sz;
      int nb;
      logic [31:0] a;
      logic [1:0] resp;
      st = 1'($urandom_range(0, 1));
      sz = st ? $urandom_range(0, 2) : $urandom_range(0, 4);
      nb = nbytes(sz);
      a = $urandom;
      if ($urandom_range(0, 3) != 0)
        a = a & ~(32'(nb) - 32'd1);
      resp = ($urandom_range(0, 3) == 0)
           ? 2'($urandom_range(1, 3)) : 2'b00;
      run_op(st, sz, a, $urandom, $urandom, resp,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
